// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: covers load-use, divide
// occupancy, data-memory wait and branch redirect, which bypassing cannot resolve.
module hazard_unit #(
  parameter int REG_NUM_WIDTH = 5,
  parameter int DIV_LATENCY   = 4,
  parameter bit WB_BYPASS     = 1'b1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [REG_NUM_WIDTH-1:0] idRs1,
  input  logic [REG_NUM_WIDTH-1:0] idRs2,
  input  logic                     idRs1Used,
  input  logic                     idRs2Used,
  input  logic [REG_NUM_WIDTH-1:0] idRd,
  input  logic                     idRegWrite,
  input  logic                     idIsLoad,
  input  logic                     idIsDiv,
  input  logic                     exBranchTaken,
  input  logic                     memReady,
  output logic                     stallIF,
  output logic                     stallID,
  output logic                     stallEX,
  output logic                     stallMEM,
  output logic                     flushID,
  output logic                     bubbleEX,
  output logic                     bubbleMEM,
  output logic                     flush,
  output logic [CNT_WIDTH-1:0]     loadUseCount
);

  // state    | meaning
  // IDLE     | no divide is holding EX
  // DIV_BUSY | divide occupies EX; div_cnt_q counts its remaining stall cycles
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] DIV_BUSY = 1'b1;

  localparam int                   DCW        = 5;
  localparam logic [DCW-1:0]       DIV_ONE    = 1;
  localparam logic [DCW-1:0]       DIV_RELOAD = DCW'(DIV_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = 1;

  // Only EX needs the load flag; divide occupancy lives in the FSM, and MEM/WB
  // only need enough to detect a pending register write.
  typedef struct packed {
    logic                     valid;
    logic [REG_NUM_WIDTH-1:0] rd;
    logic                     reg_write;
    logic                     is_load;
  } ex_rec_t;

  typedef struct packed {
    logic                     valid;
    logic [REG_NUM_WIDTH-1:0] rd;
    logic                     reg_write;
  } wr_rec_t;

  ex_rec_t              ex_q, ex_d;
  wr_rec_t              mem_q, mem_d;
  wr_rec_t              wb_q, wb_d;
  logic [0:0]           state_q, state_d;
  logic [DCW-1:0]       div_cnt_q, div_cnt_d;
  logic [CNT_WIDTH-1:0] lu_cnt_q, lu_cnt_d;

  logic stall_if_c, stall_id_c, stall_ex_c, stall_mem_c;
  logic flush_id_c, bubble_ex_c, bubble_mem_c;
  logic load_use, wb_haz, div_busy;

  function automatic logic writes_reg(input logic v, input logic rw,
                                      input logic [REG_NUM_WIDTH-1:0] rd,
                                      input logic [REG_NUM_WIDTH-1:0] r);
    return v && rw && (rd == r) && (r != '0);
  endfunction

  assign load_use = ex_q.is_load &&
                    ((idRs1Used && writes_reg(ex_q.valid, ex_q.reg_write, ex_q.rd, idRs1)) ||
                     (idRs2Used && writes_reg(ex_q.valid, ex_q.reg_write, ex_q.rd, idRs2)));

  assign wb_haz = (WB_BYPASS == 1'b0) &&
                  ((idRs1Used && writes_reg(wb_q.valid, wb_q.reg_write, wb_q.rd, idRs1)) ||
                   (idRs2Used && writes_reg(wb_q.valid, wb_q.reg_write, wb_q.rd, idRs2)));

  assign div_busy = (state_q == DIV_BUSY);

  always_comb begin
    stall_if_c   = 1'b0;
    stall_id_c   = 1'b0;
    stall_ex_c   = 1'b0;
    stall_mem_c  = 1'b0;
    flush_id_c   = 1'b0;
    bubble_ex_c  = 1'b0;
    bubble_mem_c = 1'b0;
    ex_d         = ex_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    lu_cnt_d     = lu_cnt_q;

    if (!memReady) begin
      stall_if_c  = 1'b1;
      stall_id_c  = 1'b1;
      stall_ex_c  = 1'b1;
      stall_mem_c = 1'b1;
    end else if (div_busy) begin
      stall_if_c   = 1'b1;
      stall_id_c   = 1'b1;
      stall_ex_c   = 1'b1;
      bubble_mem_c = 1'b1;
      div_cnt_d    = div_cnt_q - DIV_ONE;
      if (div_cnt_q == DIV_ONE) begin
        state_d = IDLE;
      end
      wb_d  = mem_q;
      mem_d = '0;
    end else if (exBranchTaken) begin
      flush_id_c  = 1'b1;
      bubble_ex_c = 1'b1;
      wb_d        = mem_q;
      mem_d       = '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
      ex_d        = '0;
    end else if (load_use || wb_haz) begin
      stall_if_c  = 1'b1;
      stall_id_c  = 1'b1;
      bubble_ex_c = 1'b1;
      wb_d        = mem_q;
      mem_d       = '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
      ex_d        = '0;
      if (load_use && (lu_cnt_q != '1)) begin
        lu_cnt_d = lu_cnt_q + CNT_ONE;
      end
    end else begin
      wb_d  = mem_q;
      mem_d = '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
      ex_d  = '{valid: 1'b1, rd: idRd, reg_write: idRegWrite, is_load: idIsLoad};
      // A single-cycle divide never needs to hold EX.
      if (idIsDiv && (DIV_LATENCY > 1)) begin
        state_d   = DIV_BUSY;
        div_cnt_d = DIV_RELOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      state_q   <= IDLE;
      div_cnt_q <= '0;
      lu_cnt_q  <= '0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      lu_cnt_q  <= lu_cnt_d;
    end
  end

  // Controls are forced low while reset is held, independent of memReady.
  assign stallIF      = rstn & stall_if_c;
  assign stallID      = rstn & stall_id_c;
  assign stallEX      = rstn & stall_ex_c;
  assign stallMEM     = rstn & stall_mem_c;
  assign flushID      = rstn & flush_id_c;
  assign bubbleEX     = rstn & bubble_ex_c;
  assign bubbleMEM    = rstn & bubble_mem_c;
  assign flush        = rstn & flush_id_c;
  assign loadUseCount = lu_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: two instances (WB bypass on / off with a
// narrow saturating counter) checked against a behavioural pipeline model.
module tb_hazard_unit;

  localparam int DL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [4:0] idRs1, idRs2, idRd;
  logic       idRs1Used, idRs2Used, idRegWrite, idIsLoad, idIsDiv;
  logic       exBranchTaken, memReady;

  logic        a_sif, a_sid, a_sex, a_smem, a_fid, a_bex, a_bmem, a_fl;
  logic [15:0] a_cnt;
  logic        b_sif, b_sid, b_sex, b_smem, b_fid, b_bex, b_bmem, b_fl;
  logic [2:0]  b_cnt;

  hazard_unit #(.REG_NUM_WIDTH(5), .DIV_LATENCY(DL), .WB_BYPASS(1'b1), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rstn(rstn), .idRs1(idRs1), .idRs2(idRs2), .idRs1Used(idRs1Used),
    .idRs2Used(idRs2Used), .idRd(idRd), .idRegWrite(idRegWrite), .idIsLoad(idIsLoad),
    .idIsDiv(idIsDiv), .exBranchTaken(exBranchTaken), .memReady(memReady),
    .stallIF(a_sif), .stallID(a_sid), .stallEX(a_sex), .stallMEM(a_smem),
    .flushID(a_fid), .bubbleEX(a_bex), .bubbleMEM(a_bmem), .flush(a_fl),
    .loadUseCount(a_cnt));

  hazard_unit #(.REG_NUM_WIDTH(5), .DIV_LATENCY(DL), .WB_BYPASS(1'b0), .CNT_WIDTH(3)) u_b (
    .clk(clk), .rstn(rstn), .idRs1(idRs1), .idRs2(idRs2), .idRs1Used(idRs1Used),
    .idRs2Used(idRs2Used), .idRd(idRd), .idRegWrite(idRegWrite), .idIsLoad(idIsLoad),
    .idIsDiv(idIsDiv), .exBranchTaken(exBranchTaken), .memReady(memReady),
    .stallIF(b_sif), .stallID(b_sid), .stallEX(b_sex), .stallMEM(b_smem),
    .flushID(b_fid), .bubbleEX(b_bex), .bubbleMEM(b_bmem), .flush(b_fl),
    .loadUseCount(b_cnt));

  // ctl = {stallIF, stallID, stallEX, stallMEM, flushID, bubbleEX, bubbleMEM, flush}
  typedef struct packed {
    logic [7:0]  ctl;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    obs_t a;
    obs_t b;
  } item_t;

  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit ld;
  } mrec_t;

  item_t sb[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Model: instructions in EX/MEM/WB plus "extra cycles the divide still needs".
  mrec_t m_ex[2], m_mem[2], m_wb[2];
  int    m_left[2];
  int    m_cnt[2];

  function automatic bit hits(input mrec_t r, input int reg_n);
    return r.v && r.rw && (r.rd == reg_n) && (reg_n != 0);
  endfunction

  task automatic model_step(input int k, input bit wbb, input int cmax, output obs_t o);
    mrec_t nop_r;
    bit    lu, wh;
    nop_r = '{1'b0, 0, 1'b0, 1'b0};
    o = '0;
    if (!rstn) begin
      m_ex[k] = nop_r; m_mem[k] = nop_r; m_wb[k] = nop_r;
      m_left[k] = 0;   m_cnt[k] = 0;
    end else begin
      o.cnt = 16'(m_cnt[k]);
      lu = m_ex[k].ld && ((idRs1Used && hits(m_ex[k], int'(idRs1))) ||
                          (idRs2Used && hits(m_ex[k], int'(idRs2))));
      wh = !wbb && ((idRs1Used && hits(m_wb[k], int'(idRs1))) ||
                    (idRs2Used && hits(m_wb[k], int'(idRs2))));
      if (!memReady) begin
        o.ctl = 8'b1111_0000;
      end else if (m_left[k] > 0) begin
        o.ctl = 8'b1110_0010;
        m_left[k] = m_left[k] - 1;
        m_wb[k] = m_mem[k]; m_mem[k] = nop_r;
      end else if (exBranchTaken) begin
        o.ctl = 8'b0000_1101;
        m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = nop_r;
      end else if (lu || wh) begin
        o.ctl = 8'b1100_0100;
        m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = nop_r;
        if (lu && m_cnt[k] < cmax) m_cnt[k] = m_cnt[k] + 1;
      end else begin
        m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k];
        m_ex[k] = '{1'b1, int'(idRd), idRegWrite, idIsLoad};
        if (idIsDiv && DL > 1) m_left[k] = DL - 1;
      end
    end
  endtask

  task automatic cyc(input int rs1, input int rs2, input bit u1, input bit u2,
                     input int rd, input bit rw, input bit ld, input bit dv,
                     input bit br, input bit mr, input bit rst);
    item_t it;
    @(negedge clk);
    idRs1 = 5'(rs1); idRs2 = 5'(rs2); idRs1Used = u1; idRs2Used = u2;
    idRd = 5'(rd); idRegWrite = rw; idIsLoad = ld; idIsDiv = dv;
    exBranchTaken = br; memReady = mr; rstn = rst;
    model_step(0, 1'b1, 65535, it.a);
    model_step(1, 1'b0, 7, it.b);
    sb.push_back(it);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  item_t mon_e;
  obs_t  act_a, act_b;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        act_a.ctl = {a_sif, a_sid, a_sex, a_smem, a_fid, a_bex, a_bmem, a_fl};
        act_a.cnt = a_cnt;
        act_b.ctl = {b_sif, b_sid, b_sex, b_smem, b_fid, b_bex, b_bmem, b_fl};
        act_b.cnt = {13'b0, b_cnt};
        vectors = vectors + 2;
        if (act_a !== mon_e.a) begin
          miscompares++;
          $display("FAIL u_a @%0t: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                   $time, act_a.ctl, act_a.cnt, mon_e.a.ctl, mon_e.a.cnt);
        end
        if (act_b !== mon_e.b) begin
          miscompares++;
          $display("FAIL u_b @%0t: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                   $time, act_b.ctl, act_b.cnt, mon_e.b.ctl, mon_e.b.cnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; idRs1 = '0; idRs2 = '0; idRd = '0;
    idRs1Used = 1'b0; idRs2Used = 1'b0; idRegWrite = 1'b0; idIsLoad = 1'b0;
    idIsDiv = 1'b0; exBranchTaken = 1'b0; memReady = 1'b1;

    // args: rs1, rs2, u1, u2, rd, rw, ld, dv, br, mr, rst
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(2);
    // lw x5 ; add x6,x5,x1
    cyc(1, 0, 1, 0, 5, 1, 1, 0, 0, 1, 1);
    cyc(5, 1, 1, 1, 6, 1, 0, 0, 0, 1, 1);
    cyc(5, 1, 1, 1, 6, 1, 0, 0, 0, 1, 1);
    nop(3);
    // lw x0 ; add x6,x0,x0   and   lw x5 ; add x6,x7,x8
    cyc(1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1);
    cyc(0, 0, 1, 1, 6, 1, 0, 0, 0, 1, 1);
    cyc(1, 0, 1, 0, 5, 1, 1, 0, 0, 1, 1);
    cyc(7, 8, 1, 1, 6, 1, 0, 0, 0, 1, 1);
    nop(3);
    // div x3 ; add x4,x3,x3 held through the divide
    cyc(1, 2, 1, 1, 3, 1, 0, 1, 0, 1, 1);
    for (int i = 0; i < DL; i++) cyc(3, 3, 1, 1, 4, 1, 0, 0, 0, 1, 1);
    nop(3);
    // back-to-back divides
    cyc(1, 2, 1, 1, 3, 1, 0, 1, 0, 1, 1);
    for (int i = 0; i < DL; i++) cyc(3, 3, 1, 1, 4, 1, 0, 1, 0, 1, 1);
    nop(DL + 1);
    // branch taken over a load-use match
    cyc(1, 0, 1, 0, 5, 1, 1, 0, 0, 1, 1);
    cyc(5, 1, 1, 1, 6, 1, 0, 0, 1, 1, 1);
    nop(3);
    // memory wait during load-use
    cyc(1, 0, 1, 0, 5, 1, 1, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 1);
    cyc(5, 1, 1, 1, 6, 1, 0, 0, 0, 1, 1);
    cyc(5, 1, 1, 1, 6, 1, 0, 0, 0, 1, 1);
    nop(3);
    // reset in the middle of a divide
    cyc(1, 2, 1, 1, 3, 1, 0, 1, 0, 1, 1);
    cyc(3, 3, 1, 1, 4, 1, 0, 0, 0, 1, 1);
    cyc(3, 3, 1, 1, 4, 1, 0, 0, 0, 1, 0);
    cyc(3, 3, 1, 1, 4, 1, 0, 0, 0, 1, 1);
    nop(2);
    // WB-stage match: writer of x5, two nops, then a reader
    cyc(1, 2, 1, 1, 5, 1, 0, 0, 0, 1, 1);
    nop(2);
    cyc(5, 5, 1, 1, 6, 1, 0, 0, 0, 1, 1);
    cyc(5, 5, 1, 1, 6, 1, 0, 0, 0, 1, 1);
    nop(2);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
          $urandom_range(0, 3), $urandom_range(0, 4) != 0,
          $urandom_range(0, 9) < 3, $urandom_range(0, 24) < 2,
          $urandom_range(0, 7) == 0, $urandom_range(0, 6) != 0,
          $urandom_range(0, 299) != 0);
    end
    nop(1);

    @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d items left in scoreboard, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
